trdb_branch_map_buf: RTL and testbench
======================================

Name: trdb_branch_map_buf

Overview:
Parametrised branch-map accumulator with an output queue for the instruction trace encoder. It collects taken/not-taken outcomes from up to NUM_BR branches retired per cycle into a MAP_LEN-bit map. A map is pushed into a DEPTH-entry FIFO when it fills or on flush. The packet emitter drains the FIFO with a valid/ready handshake, so branch history is kept while the emitter is stalled.

Parameters:
MAP_LEN, 31, branch map capacity in bits; legal 1..64
CNT_W, $clog2(MAP_LEN+1) (5), width of count fields
NUM_BR, 2, branch lanes per cycle; legal 1..4 and NUM_BR <= MAP_LEN
DEPTH, 2, FIFO entries; legal >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
branch_valid_i  in  NUM_BR  lane k retired a branch this cycle
branch_taken_i  in  NUM_BR  lane k outcome, 1 = taken
flush_i  in  1  push current partial map
out_valid_o  out  1  FIFO head valid
out_ready_i  in  1  emitter accepts head
out_map_o  out  MAP_LEN  head map; bit i = i-th oldest branch, 1 = NOT taken
out_count_o  out  CNT_W  head branch count, 1..MAP_LEN
out_full_o  out  1  head map was pushed because it reached MAP_LEN
cur_count_o  out  CNT_W  branches in the accumulator now
overflow_o  out  1  sticky: a map was dropped because the FIFO was full

Behaviour:
- Reset (async, any time): accumulator, count, FIFO pointers and occupancy, and overflow_o clear. All outputs read 0, including out_map_o. In-flight maps are discarded.
- Lane order: lane 0 is the oldest. Valid lanes need not be contiguous; only valid lanes are compacted and appended. Appended bit = ~branch_taken_i.
- Let n = number of valid lanes and c = cur count.
  - If c+n < MAP_LEN: append bits, c += n.
  - If c+n >= MAP_LEN: fill bits c..MAP_LEN-1 and push that map with full=1. The remaining c+n-MAP_LEN bits start the new accumulator at bit 0.
- Accumulator bits at or above the count are always 0, including pushed maps.
- flush_i: after this cycle's branches are appended, and after any full push, the residual accumulator is pushed with full=0 if its count > 0. The accumulator then clears. Flush with residual count 0 pushes nothing.
- A single cycle therefore produces 0, 1 or 2 pushes. When there are 2, the full map is written first.
- FIFO:
  - Free slots = DEPTH - occupancy + pop, where pop = out_valid_o & out_ready_i in the same cycle.
  - Pushes beyond the free slots are dropped, newest first, and overflow_o sets.
  - overflow_o holds until reset.
  - Dropping never corrupts existing entries. The accumulator still updates as if the push had succeeded.
- Latency: a push in cycle N is visible at the head in cycle N+1 if the FIFO was empty, or after all older entries have been popped.
- Handshake:
  - Head outputs are registered and stable while out_valid_o=1 and out_ready_i=0.
  - out_valid_o does not depend combinationally on out_ready_i.
  - Pop and push in the same cycle are both honoured.
- cur_count_o is registered and reflects the accumulator after the previous edge.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are decided by occupancy, not pointer equality; non-power-of-2 DEPTH is legal.

Test Plan:
- Assert rst_i mid-cycle, asynchronously -> all outputs 0 immediately, before the next clock edge; cur_count_o=0 after release.
- MAP_LEN=31: 31 cycles of lane0 valid, taken=0 -> cycle after the 31st: out_valid_o=1, out_map_o=0x7FFFFFFF, out_count_o=31, out_full_o=1, cur_count_o=0.
- c=30 (all taken, so bits 0), then lane0 not-taken and lane1 taken in one cycle -> pushed map=0x40000000, count=31, full=1; cur_count_o=1 with accumulator bit0=0.
- c=3 with bits 0b101, then flush_i together with lane1 only valid, not-taken (lane0 invalid) -> pushed map=0xD, count=4, full=0; cur_count_o=0.
- c=30, both lanes valid, plus flush_i, FIFO empty -> two pushes: entry0 count=31 full=1, entry1 count=1 full=0; overflow_o stays 0.
- DEPTH=2, out_ready_i=0, produce 3 flushed maps (counts 1, 2, 3) -> FIFO holds counts 1 and 2, overflow_o=1. Then out_ready_i=1 -> counts 1 and 2 pop on consecutive cycles, then out_valid_o=0.

Source files
------------

// File: rtl/trdb_branch_map_buf.sv
// rtl/trdb_branch_map_buf.sv - branch-map accumulator with a DEPTH-entry output queue
// Packs per-lane taken/not-taken outcomes into MAP_LEN-bit maps and queues them for the packet emitter.
module trdb_branch_map_buf #(
  parameter int MAP_LEN = 31,
  parameter int CNT_W   = $clog2(MAP_LEN + 1),
  parameter int NUM_BR  = 2,
  parameter int DEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BR-1:0]  branch_valid_i,
  input  logic [NUM_BR-1:0]  branch_taken_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [MAP_LEN-1:0] out_map_o,
  output logic [CNT_W-1:0]   out_count_o,
  output logic               out_full_o,
  output logic [CNT_W-1:0]   cur_count_o,
  output logic               overflow_o
);

  localparam int EXT_W = 2 * MAP_LEN;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [7:0] MAP_LEN8 = 8'(MAP_LEN);

  logic [MAP_LEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               ovf_q, ovf_d;

  logic [MAP_LEN-1:0] mem_map_q  [DEPTH];
  logic [CNT_W-1:0]   mem_cnt_q  [DEPTH];
  logic               mem_full_q [DEPTH];

  logic [EXT_W-1:0]   ext;
  logic [7:0]         total, res_cnt;
  logic [MAP_LEN-1:0] full_map, res_map;
  logic               full_push, flush_push;

  logic [MAP_LEN-1:0] p0_map;
  logic [CNT_W-1:0]   p0_cnt;
  logic               p0_full, p0_vld, p1_vld;
  logic               acc0, acc1, pop;
  logic [OCC_W:0]     free;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Compact the valid lanes (lane 0 oldest) onto the accumulator in a double-width scratch vector.
  always_comb begin
    ext   = EXT_W'(acc_q);
    total = 8'(cnt_q);
    for (int k = 0; k < NUM_BR; k++) begin
      if (branch_valid_i[k]) begin
        ext   = ext | (EXT_W'(!branch_taken_i[k]) << total);
        total = total + 8'd1;
      end
    end
  end

  always_comb begin
    full_push = (total >= MAP_LEN8);
    full_map  = '0;
    res_map   = ext[MAP_LEN-1:0];
    res_cnt   = total;
    if (full_push) begin
      full_map = ext[MAP_LEN-1:0];
      res_map  = ext[EXT_W-1:MAP_LEN];
      res_cnt  = total - MAP_LEN8;
    end
    flush_push = flush_i && (res_cnt != 8'd0);

    acc_d = flush_i ? '0 : res_map;
    cnt_d = flush_i ? '0 : CNT_W'(res_cnt);

    // Slot 0 holds the full map when there is one; the flushed residual then goes in slot 1.
    p0_vld  = full_push || flush_push;
    p1_vld  = full_push && flush_push;
    p0_map  = full_push ? full_map : res_map;
    p0_cnt  = full_push ? CNT_W'(MAP_LEN) : CNT_W'(res_cnt);
    p0_full = full_push;

    pop  = out_valid_o && out_ready_i;
    free = (OCC_W+1)'(DEPTH) - {1'b0, occ_q} + (OCC_W+1)'(pop);
    acc0 = p0_vld && (free != '0);
    acc1 = p1_vld && (free >= (OCC_W+1)'(2));

    ovf_d      = ovf_q || (p0_vld && !acc0) || (p1_vld && !acc1);
    wr_ptr_nxt = ptr_inc(wr_ptr_q);
    wr_ptr_d   = wr_ptr_q;
    if (acc1)      wr_ptr_d = ptr_inc(wr_ptr_nxt);
    else if (acc0) wr_ptr_d = wr_ptr_nxt;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(acc0) + OCC_W'(acc1) - OCC_W'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (acc0) begin
      mem_map_q[wr_ptr_q]  <= p0_map;
      mem_cnt_q[wr_ptr_q]  <= p0_cnt;
      mem_full_q[wr_ptr_q] <= p0_full;
    end
    if (acc1) begin
      mem_map_q[wr_ptr_nxt]  <= res_map;
      mem_cnt_q[wr_ptr_nxt]  <= CNT_W'(res_cnt);
      mem_full_q[wr_ptr_nxt] <= 1'b0;
    end
  end

  assign out_valid_o = (occ_q != '0);
  assign out_map_o   = out_valid_o ? mem_map_q[rd_ptr_q] : '0;
  assign out_count_o = out_valid_o ? mem_cnt_q[rd_ptr_q] : '0;
  assign out_full_o  = out_valid_o && mem_full_q[rd_ptr_q];
  assign cur_count_o = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_trdb_branch_map_buf.sv
// tb/tb_trdb_branch_map_buf.sv - directed self-checking bench for trdb_branch_map_buf
module tb_trdb_branch_map_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bv = '0;
  logic [1:0]  bt = '0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic        valid;
  logic [30:0] map;
  logic [4:0]  cnt;
  logic        full;
  logic [4:0]  cur;
  logic        ovf;

  int n_pass = 0;
  int n_total = 0;

  trdb_branch_map_buf #(.MAP_LEN(31), .NUM_BR(2), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .branch_valid_i(bv), .branch_taken_i(bt), .flush_i(flush),
    .out_valid_o(valid), .out_ready_i(ready), .out_map_o(map), .out_count_o(cnt),
    .out_full_o(full), .cur_count_o(cur), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ready = 0; bv = 2'b01; bt = 2'b00; flush = 1;
    cyc();
    flush = 0;
    cyc();
    bv = 0;
    n_total++; if (cur !== 5'd1) $display("FAIL rst_pre_cur: got %0d expected 1", cur); else n_pass++;
    n_total++; if (valid !== 1'b1) $display("FAIL rst_pre_valid: got %0b expected 1", valid); else n_pass++;
    #3 rst = 1;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL rst_async_valid: got %0b expected 0", valid); else n_pass++;
    n_total++; if (map !== 31'h0) $display("FAIL rst_async_map: got %h expected 0", map); else n_pass++;
    n_total++; if (cnt !== 5'd0) $display("FAIL rst_async_count: got %0d expected 0", cnt); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL rst_async_full: got %0b expected 0", full); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL rst_async_cur: got %0d expected 0", cur); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rst_async_ovf: got %0b expected 0", ovf); else n_pass++;
    #2 rst = 0;
    cyc();
    n_total++; if (cur !== 5'd0) $display("FAIL rst_after_cur: got %0d expected 0", cur); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL rst_after_valid: got %0b expected 0", valid); else n_pass++;
  endtask

  task automatic test_full_map();
    ready = 0; bv = 2'b01; bt = 2'b00;
    repeat (31) cyc();
    bv = 0;
    n_total++; if (valid !== 1'b1) $display("FAIL full_valid: got %0b expected 1", valid); else n_pass++;
    n_total++; if (map !== 31'h7FFFFFFF) $display("FAIL full_map: got %h expected 7fffffff", map); else n_pass++;
    n_total++; if (cnt !== 5'd31) $display("FAIL full_count: got %0d expected 31", cnt); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL full_flag: got %0b expected 1", full); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL full_cur: got %0d expected 0", cur); else n_pass++;
    ready = 1;
    cyc();
    n_total++; if (valid !== 1'b0) $display("FAIL full_drain: got %0b expected 0", valid); else n_pass++;
    ready = 0;
  endtask

  task automatic test_carry();
    bv = 2'b11; bt = 2'b11;
    repeat (15) cyc();
    n_total++; if (cur !== 5'd30) $display("FAIL carry_pre_cur: got %0d expected 30", cur); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL carry_pre_valid: got %0b expected 0", valid); else n_pass++;
    bt = 2'b10;
    cyc();
    bv = 0;
    n_total++; if (map !== 31'h40000000) $display("FAIL carry_map: got %h expected 40000000", map); else n_pass++;
    n_total++; if (cnt !== 5'd31) $display("FAIL carry_count: got %0d expected 31", cnt); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL carry_full: got %0b expected 1", full); else n_pass++;
    n_total++; if (cur !== 5'd1) $display("FAIL carry_cur: got %0d expected 1", cur); else n_pass++;
    flush = 1;
    cyc();
    flush = 0;
    n_total++; if (map !== 31'h40000000) $display("FAIL carry_stall_map: got %h expected 40000000", map); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL carry_flush_cur: got %0d expected 0", cur); else n_pass++;
    ready = 1;
    cyc();
    n_total++; if (valid !== 1'b1) $display("FAIL carry_res_valid: got %0b expected 1", valid); else n_pass++;
    n_total++; if (map !== 31'h0) $display("FAIL carry_res_map: got %h expected 0", map); else n_pass++;
    n_total++; if (cnt !== 5'd1) $display("FAIL carry_res_count: got %0d expected 1", cnt); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL carry_res_full: got %0b expected 0", full); else n_pass++;
    cyc();
    n_total++; if (valid !== 1'b0) $display("FAIL carry_drain: got %0b expected 0", valid); else n_pass++;
    ready = 0;
  endtask

  task automatic test_flush_partial();
    bv = 2'b01; bt = 2'b00; cyc();
    bt = 2'b01; cyc();
    bt = 2'b00; cyc();
    n_total++; if (cur !== 5'd3) $display("FAIL part_pre_cur: got %0d expected 3", cur); else n_pass++;
    bv = 2'b10; bt = 2'b00; flush = 1;
    cyc();
    bv = 0; flush = 0;
    n_total++; if (map !== 31'hD) $display("FAIL part_map: got %h expected d", map); else n_pass++;
    n_total++; if (cnt !== 5'd4) $display("FAIL part_count: got %0d expected 4", cnt); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL part_full: got %0b expected 0", full); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL part_cur: got %0d expected 0", cur); else n_pass++;
    flush = 1;
    ready = 1;
    cyc();
    flush = 0;
    n_total++; if (valid !== 1'b0) $display("FAIL part_empty_flush: got %0b expected 0", valid); else n_pass++;
    ready = 0;
  endtask

  task automatic test_double_push();
    bv = 2'b11; bt = 2'b11;
    repeat (15) cyc();
    bt = 2'b00; flush = 1;
    cyc();
    bv = 0; flush = 0;
    n_total++; if (map !== 31'h40000000) $display("FAIL dbl_e0_map: got %h expected 40000000", map); else n_pass++;
    n_total++; if (cnt !== 5'd31) $display("FAIL dbl_e0_count: got %0d expected 31", cnt); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL dbl_e0_full: got %0b expected 1", full); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL dbl_cur: got %0d expected 0", cur); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL dbl_ovf: got %0b expected 0", ovf); else n_pass++;
    ready = 1;
    cyc();
    n_total++; if (map !== 31'h1) $display("FAIL dbl_e1_map: got %h expected 1", map); else n_pass++;
    n_total++; if (cnt !== 5'd1) $display("FAIL dbl_e1_count: got %0d expected 1", cnt); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL dbl_e1_full: got %0b expected 0", full); else n_pass++;
    cyc();
    n_total++; if (valid !== 1'b0) $display("FAIL dbl_drain: got %0b expected 0", valid); else n_pass++;
    ready = 0;
  endtask

  task automatic test_back_to_back();
    ready = 0; bv = 2'b01; bt = 2'b00; flush = 1;
    cyc();
    bv = 2'b11; bt = 2'b00;
    cyc();
    ready = 1; bv = 2'b01; bt = 2'b01;
    cyc();
    bv = 0; flush = 0;
    n_total++; if (map !== 31'h3) $display("FAIL b2b_head1_map: got %h expected 3", map); else n_pass++;
    n_total++; if (cnt !== 5'd2) $display("FAIL b2b_head1_count: got %0d expected 2", cnt); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL b2b_ovf: got %0b expected 0", ovf); else n_pass++;
    cyc();
    n_total++; if (map !== 31'h0) $display("FAIL b2b_head2_map: got %h expected 0", map); else n_pass++;
    n_total++; if (cnt !== 5'd1) $display("FAIL b2b_head2_count: got %0d expected 1", cnt); else n_pass++;
    cyc();
    n_total++; if (valid !== 1'b0) $display("FAIL b2b_drain: got %0b expected 0", valid); else n_pass++;
    ready = 0;
  endtask

  task automatic test_overflow();
    ready = 0; bv = 2'b01; bt = 2'b00; flush = 1;
    cyc();
    bv = 2'b11;
    cyc();
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_early: got %0b expected 0", ovf); else n_pass++;
    bv = 2'b01; flush = 0;
    cyc();
    bv = 2'b11; flush = 1;
    cyc();
    bv = 0; flush = 0;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", ovf); else n_pass++;
    n_total++; if (cnt !== 5'd1) $display("FAIL ovf_head0_count: got %0d expected 1", cnt); else n_pass++;
    n_total++; if (map !== 31'h1) $display("FAIL ovf_head0_map: got %h expected 1", map); else n_pass++;
    n_total++; if (cur !== 5'd0) $display("FAIL ovf_cur: got %0d expected 0", cur); else n_pass++;
    ready = 1;
    cyc();
    n_total++; if (cnt !== 5'd2) $display("FAIL ovf_head1_count: got %0d expected 2", cnt); else n_pass++;
    n_total++; if (map !== 31'h3) $display("FAIL ovf_head1_map: got %h expected 3", map); else n_pass++;
    cyc();
    n_total++; if (valid !== 1'b0) $display("FAIL ovf_drain: got %0b expected 0", valid); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", ovf); else n_pass++;
    ready = 0;
    rst = 1;
    #1;
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_reset_clear: got %0b expected 0", ovf); else n_pass++;
    #2 rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_full_map();
    test_carry();
    test_flush_partial();
    test_double_push();
    test_back_to_back();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
